// File: rtl/cpu_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : cpu_reg_file_sb
// Purpose  : Multi-port integer register file with a per-register busy
//            scoreboard for RAW hazard detection at decode/issue.
//            x0 is hardwired to zero and is never busy.
// Ports    :
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   ra        - NUM_RD packed read addresses
//   rd        - NUM_RD packed read data (combinational)
//   rd_busy   - per read port: addressed register has a pending producer
//   wen/wa/wd - NUM_WR write ports, higher index has higher priority
//   iss_en    - issue strobe, marks iss_addr busy
//   iss_addr  - destination register of the issued instruction
//   flush     - clears every busy bit
//   busy_cnt  - registered number of busy registers
// Revision : 1.0 - initial release
// ============================================================================
module cpu_reg_file_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          busy_cnt
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 busy;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] wr_data;
    logic [NUM_REGS-1:0]                 wr_hit;
    logic [NUM_REGS-1:0]                 busy_nxt;
    logic [ADDR_WIDTH:0]                 busy_cnt_nxt;

    // Per-register write decode. Ports are scanned in ascending order so the
    // highest-index enabled port targeting a register supplies its data.
    // Address 0 never produces a hit, which keeps x0 at zero.
    always_comb begin
        wr_hit  = '0;
        wr_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wen[k] && (r != 0) &&
                    (wa[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = wd[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Busy next state: flush, then issue, then writeback. Issue beats a
    // same-cycle writeback because the new producer is still outstanding.
    always_comb begin
        busy_nxt     = busy;
        busy_cnt_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (iss_en && (r != 0) && (iss_addr == ADDR_WIDTH'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end
            busy_cnt_nxt = busy_cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    // Read ports: stored value, optionally overridden by a same-cycle write.
    // A forwarded read is not busy since the producer's data is on the port.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  fwd;

        assign addr = ra[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data = regs[addr];
            fwd  = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wen[k] && (addr != '0) &&
                        (wa[k*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
                        data = wd[k*DATA_WIDTH +: DATA_WIDTH];
                        fwd  = 1'b1;
                    end
                end
            end
        end

        assign rd[i*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[i]                     = busy[addr] & ~fwd;
    end

    // Design checks
    for (genvar k = 0; k < NUM_WR; k++) begin : g_x0_chk
        a_no_x0_write : assert property (@(posedge clk) disable iff (!rst_n)
            !(wen[k] && (wa[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)))
            else $warning("write port %0d targets x0; data discarded", k);
    end

    a_busy_cnt : assert property (@(posedge clk) disable iff (!rst_n)
        (busy_cnt == ($countones(busy)))) else $error("busy_cnt out of step with busy vector");

endmodule
`default_nettype wire

// File: tb/tb_cpu_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_reg_file_sb
// Purpose  : Scoreboard bench for cpu_reg_file_sb. Stimulus drives inputs just
//            after each rising edge and queues the expected outputs; a monitor
//            on the falling edge pops and compares them. A second instance with
//            BYPASS=0 shares the inputs to check non-forwarded reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_reg_file_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [2*AW-1:0] ra;
    logic [2*DW-1:0] rd,      nb_rd;
    logic [1:0]      rd_busy, nb_rd_busy;
    logic [1:0]      wen;
    logic [2*AW-1:0] wa;
    logic [2*DW-1:0] wd;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            flush;
    logic [AW:0]     busy_cnt, nb_busy_cnt;

    cpu_reg_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .wen(wen), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    cpu_reg_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(nb_rd), .rd_busy(nb_rd_busy),
        .wen(wen), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_cnt(nb_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 rd, 1 rd_busy, 2 busy_cnt, 3 rd (BYPASS=0), 4 rd_busy (BYPASS=0)
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = rd[e.port*DW +: DW];
                1:       act = {31'd0, rd_busy[e.port]};
                2:       act = {26'd0, busy_cnt};
                3:       act = nb_rd[e.port*DW +: DW];
                default: act = {31'd0, nb_rd_busy[e.port]};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.val);
            end
        end
    end

    task automatic expect_v(input string n, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = kind; e.port = port; e.val = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra = '0; wen = '0; wa = '0; wd = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic set_ra(input int p, input int a);
        ra[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int k, input int a, input logic [31:0] d);
        wen[k]         = 1'b1;
        wa[k*AW +: AW] = AW'(a);
        wd[k*DW +: DW] = d;
    endtask

    task automatic issue(input int a);
        iss_en   = 1'b1;
        iss_addr = AW'(a);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        // 1. every address reads zero and idle after reset
        for (int a = 0; a < 32; a++) begin
            idle();
            set_ra(0, a); set_ra(1, a);
            expect_v("reset_rd", 0, 0, 32'h0);
            expect_v("reset_rd", 0, 1, 32'h0);
            expect_v("reset_busy", 1, 0, 32'h0);
            expect_v("reset_busy", 1, 1, 32'h0);
            expect_v("reset_cnt", 2, 0, 32'h0);
            step();
        end

        // 2. same-cycle write/read of x5
        idle(); wr(0, 5, 32'hDEADBEEF); set_ra(0, 5);
        expect_v("bypass_rd", 0, 0, 32'hDEADBEEF);
        expect_v("nobypass_rd_same", 3, 0, 32'h0);
        step();
        idle(); set_ra(0, 5);
        expect_v("stored_rd", 0, 0, 32'hDEADBEEF);
        expect_v("nobypass_rd_next", 3, 0, 32'hDEADBEEF);
        step();

        // 3. write-port priority on x7, then a write to x0
        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); set_ra(0, 7);
        expect_v("prio_bypass", 0, 0, 32'h22);
        expect_v("prio_nobypass_old", 3, 0, 32'h0);
        step();
        idle(); wr(0, 0, 32'hFFFF); set_ra(0, 7); set_ra(1, 0);
        expect_v("prio_stored", 0, 0, 32'h22);
        expect_v("prio_stored_nb", 3, 0, 32'h22);
        expect_v("x0_bypass", 0, 1, 32'h0);
        expect_v("x0_bypass_nb", 3, 1, 32'h0);
        step();
        idle(); set_ra(1, 0);
        expect_v("x0_after_write", 0, 1, 32'h0);
        expect_v("x0_after_write_nb", 3, 1, 32'h0);
        step();

        // 4. issue x3, x4, x3, then writeback x3
        idle(); issue(3); set_ra(0, 3);
        expect_v("iss_cnt0", 2, 0, 32'd0);
        expect_v("iss_busy_pre", 1, 0, 32'd0);
        step();
        idle(); issue(4); set_ra(0, 3);
        expect_v("iss_cnt1", 2, 0, 32'd1);
        expect_v("iss_busy_x3", 1, 0, 32'd1);
        step();
        idle(); issue(3);
        expect_v("iss_cnt2", 2, 0, 32'd2);
        step();
        idle(); wr(0, 3, 32'h33); set_ra(0, 3); set_ra(1, 4);
        expect_v("iss_cnt_dup", 2, 0, 32'd2);
        expect_v("wb_fwd_busy", 1, 0, 32'd0);
        expect_v("wb_fwd_busy_nb", 4, 0, 32'd1);
        expect_v("wb_fwd_rd", 0, 0, 32'h33);
        expect_v("busy_x4", 1, 1, 32'd1);
        step();
        idle(); set_ra(0, 3); set_ra(1, 4);
        expect_v("wb_cnt", 2, 0, 32'd1);
        expect_v("wb_busy_x3", 1, 0, 32'd0);
        expect_v("wb_busy_x4", 1, 1, 32'd1);
        expect_v("wb_rd_x3", 0, 0, 32'h33);
        step();

        // 5. issue and write x9 together, then flush with an issue of x10
        idle(); issue(9); wr(1, 9, 32'h99); set_ra(0, 9);
        expect_v("isswr_cnt_pre", 2, 0, 32'd1);
        expect_v("isswr_fwd_rd", 0, 0, 32'h99);
        expect_v("isswr_fwd_busy", 1, 0, 32'd0);
        step();
        idle(); set_ra(0, 9);
        expect_v("isswr_cnt", 2, 0, 32'd2);
        expect_v("isswr_busy", 1, 0, 32'd1);
        expect_v("isswr_rd", 0, 0, 32'h99);
        step();
        idle(); flush = 1'b1; issue(10); set_ra(0, 10); set_ra(1, 4);
        expect_v("flush_cnt_pre", 2, 0, 32'd2);
        expect_v("flush_busy_pre", 1, 1, 32'd1);
        step();
        idle(); issue(0); set_ra(0, 10); set_ra(1, 9);
        expect_v("flush_cnt", 2, 0, 32'd0);
        expect_v("flush_busy_x10", 1, 0, 32'd0);
        expect_v("flush_busy_x9", 1, 1, 32'd0);
        step();
        idle(); set_ra(0, 0);
        expect_v("iss_x0_cnt", 2, 0, 32'd0);
        expect_v("iss_x0_busy", 1, 0, 32'd0);
        step();

        // 6. asynchronous reset with three busy registers and a write pending
        idle(); issue(1); step();
        idle(); issue(2); step();
        idle(); issue(3); step();
        idle(); set_ra(0, 1);
        expect_v("pre_rst_cnt", 2, 0, 32'd3);
        expect_v("pre_rst_busy", 1, 0, 32'd1);
        step();
        idle(); wr(0, 12, 32'hC); issue(13); set_ra(0, 7); set_ra(1, 5);
        #2 rst_n = 1'b0;
        expect_v("arst_cnt", 2, 0, 32'd0);
        expect_v("arst_rd_x7", 0, 0, 32'h0);
        expect_v("arst_rd_x5", 0, 1, 32'h0);
        step();
        step();
        idle(); rst_n = 1'b1; set_ra(0, 12); set_ra(1, 13);
        expect_v("arst_no_write", 0, 0, 32'h0);
        expect_v("arst_no_issue", 1, 1, 32'd0);
        expect_v("arst_cnt_after", 2, 0, 32'd0);
        step();

        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
